sprite_compositor: RTL
======================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter X_WIDTH, default 9, raster x coordinate width.
REQ-002 SHALL have parameter Y_WIDTH, default 9, raster y coordinate width.
REQ-003 SHALL have parameter COLOUR_WIDTH, default 3, pixel colour width.
REQ-004 SHALL have parameter NUM_SPRITES, default 4, sprite channel count (1..8).
REQ-005 SHALL have parameter SIZE_WIDTH, default 6, sprite width/height field width.
REQ-006 SHALL have parameter BG_COLOUR, default 3'b001, fill colour where no layer is opaque.
REQ-007 SHALL have one clock and an asynchronous, active-high reset; ports: clock in 1, rising-edge clock; reset in 1, async active-high reset.
REQ-008 SHALL have ports: enable in 1 scan advance; max_x in X_WIDTH last column; max_y in Y_WIDTH last row.
REQ-009 SHALL have ports: scan_x out X_WIDTH and scan_y out Y_WIDTH, current counter; bg_flag in COLOUR_WIDTH, background colour at scan_x/scan_y, 0 = transparent.
REQ-010 SHALL have flat ports: sprite_x in NUM_SPRITES*X_WIDTH; sprite_y in NUM_SPRITES*Y_WIDTH; sprite_w and sprite_h in NUM_SPRITES*SIZE_WIDTH; sprite_colour in NUM_SPRITES*COLOUR_WIDTH; sprite_en in NUM_SPRITES; slice i = sprite i.
REQ-011 SHALL have outputs: x_out X_WIDTH, y_out Y_WIDTH, colour_out COLOUR_WIDTH, valid_out 1, frame_start 1, frame_done 1, hit_sprite NUM_SPRITES, hit_bg NUM_SPRITES.

Function
REQ-012 Scan counter SHALL advance only when enable=1: x+1; if x>=max_x then x=0 and y+1; if additionally y>=max_y then y=0 (>= handles max shrinking mid-frame).
REQ-013 Frame = (max_x+1)*(max_y+1) enabled cycles; last pixel = x>=max_x and y>=max_y.
REQ-014 Sprite i hit at (x,y) iff shadow en_i=1, sx<=x<sx+w, sy<=y<sy+h; sums SHALL be computed one bit wider (no wrap); w=0 or h=0 never hits.
REQ-015 Colour priority: lowest-index hit sprite colour; else bg_flag if nonzero; else BG_COLOUR.
REQ-016 Output latency 1 cycle: on enabled cycle, x_out/y_out/colour_out SHALL register the composited scan pixel and valid_out=1; on enable=0, valid_out=0 and other outputs hold.
REQ-017 frame_start SHALL be 1 for exactly the registered cycle whose x_out,y_out = (0,0); frame_done 1 for exactly the registered cycle of the last pixel.
REQ-018 Shadow sprite registers SHALL load from all sprite_* inputs only on an enabled last-pixel cycle; next frame uses them; mid-frame input changes SHALL not affect the current frame.
REQ-019 Sprite-sprite accumulator bit i SHALL set on any pixel where sprite i and at least one other sprite hit together.
REQ-020 Background accumulator bit i SHALL set on any pixel where sprite i hits and bg_flag!=0 (regardless of priority).
REQ-021 On the enabled last-pixel cycle, hit_sprite/hit_bg SHALL register the accumulators including that pixel, and accumulators clear; outputs hold for the whole following frame.
REQ-022 enable=0 SHALL freeze counter, accumulators and shadows.

Reset
REQ-023 Reset SHALL asynchronously clear counter, x_out, y_out, colour_out, valid_out, frame_start, frame_done, hit_sprite, hit_bg, accumulators and all shadow registers (all sprites disabled).
REQ-024 First frame after reset SHALL show no sprites; sprite inputs take effect from the second frame.
REQ-025 Reset mid-frame SHALL restart scan at (0,0) on the first enabled cycle after release; partial-frame collisions are discarded.

Verification
REQ-026 max_x=3, max_y=2, no sprites, bg_flag=0, enable=1 -> 12-cycle frames, colour_out=3'b001, frame_start every 12 cycles one cycle after scan (0,0), frame_done at (3,2).
REQ-027 Sprite0 at (1,1) w=2 h=1 colour 3'b100 -> frame 1 none, frame 2 colour 3'b100 only at (1,1),(2,1).
REQ-028 Sprite0 (0,0) 2x2 colour 3'b100, sprite1 (1,1) 2x2 colour 3'b010 -> (1,1)=3'b100, (2,2)=3'b010; after frame_done hit_sprite=2'b11 for next frame.
REQ-029 bg_flag=3'b110 at (3,0), sprite2 at (3,0) 1x1 -> hit_bg[2]=1, others 0; sprite at x=max_x w=63 causes no wrap hits at x=0.
REQ-030 Toggle enable low 5 cycles mid-frame, then change max_x 3->1 while x=2 -> valid_out=0 and outputs held while low; x wraps to 0 next enabled cycle.
REQ-031 Assert reset at scan (2,1) with hit_sprite=1 -> all outputs 0 immediately; scan resumes at (0,0).

Source files
------------

// File: rtl/sprite_compositor.sv
// sprite_compositor
//
// Raster scan counter with a fixed-priority sprite overlay. Each enabled cycle the
// counter visits one pixel, the visible colour there is composited from the shadowed
// sprite set and the supplied background colour, and the result is registered one
// cycle later. Sprite-sprite and sprite-background collisions are accumulated over a
// frame and published on the frame's last pixel.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   enable              advance the scan by one pixel this cycle
//   max_x, max_y        last column / last row of the frame
//   scan_x, scan_y      pixel currently being composited
//   bg_flag             background colour at scan_x/scan_y (0 = transparent)
//   sprite_*            flat per-sprite attributes, slice i belongs to sprite i
//   x_out, y_out        coordinates of the registered pixel
//   colour_out          composited colour of the registered pixel
//   valid_out           registered pixel is new this cycle
//   frame_start         registered pixel is (0,0)
//   frame_done          registered pixel is the last pixel of the frame
//   hit_sprite, hit_bg  collision flags of the previous complete frame

module sprite_compositor #(
  parameter int unsigned               X_WIDTH      = 9,
  parameter int unsigned               Y_WIDTH      = 9,
  parameter int unsigned               COLOUR_WIDTH = 3,
  parameter int unsigned               NUM_SPRITES  = 4,
  parameter int unsigned               SIZE_WIDTH   = 6,
  parameter logic [COLOUR_WIDTH-1:0]   BG_COLOUR    = 3'b001
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [X_WIDTH-1:0]                  max_x,
  input  logic [Y_WIDTH-1:0]                  max_y,
  output logic [X_WIDTH-1:0]                  scan_x,
  output logic [Y_WIDTH-1:0]                  scan_y,
  input  logic [COLOUR_WIDTH-1:0]             bg_flag,
  input  logic [NUM_SPRITES*X_WIDTH-1:0]      sprite_x,
  input  logic [NUM_SPRITES*Y_WIDTH-1:0]      sprite_y,
  input  logic [NUM_SPRITES*SIZE_WIDTH-1:0]   sprite_w,
  input  logic [NUM_SPRITES*SIZE_WIDTH-1:0]   sprite_h,
  input  logic [NUM_SPRITES*COLOUR_WIDTH-1:0] sprite_colour,
  input  logic [NUM_SPRITES-1:0]              sprite_en,
  output logic [X_WIDTH-1:0]                  x_out,
  output logic [Y_WIDTH-1:0]                  y_out,
  output logic [COLOUR_WIDTH-1:0]             colour_out,
  output logic                                valid_out,
  output logic                                frame_start,
  output logic                                frame_done,
  output logic [NUM_SPRITES-1:0]              hit_sprite,
  output logic [NUM_SPRITES-1:0]              hit_bg
);

  // Comparison widths: one bit wider than the widest operand so sx+w never wraps.
  localparam int unsigned XS = ((X_WIDTH > SIZE_WIDTH) ? X_WIDTH : SIZE_WIDTH) + 1;
  localparam int unsigned YS = ((Y_WIDTH > SIZE_WIDTH) ? Y_WIDTH : SIZE_WIDTH) + 1;

  // Scan counter
  logic [X_WIDTH-1:0] scan_x_q, scan_x_d;
  logic [Y_WIDTH-1:0] scan_y_q, scan_y_d;
  logic               last_x, last_y, last_pixel, first_pixel;

  // Shadow sprite set used by the frame in progress
  logic [NUM_SPRITES*X_WIDTH-1:0]      sh_x_q;
  logic [NUM_SPRITES*Y_WIDTH-1:0]      sh_y_q;
  logic [NUM_SPRITES*SIZE_WIDTH-1:0]   sh_w_q;
  logic [NUM_SPRITES*SIZE_WIDTH-1:0]   sh_h_q;
  logic [NUM_SPRITES*COLOUR_WIDTH-1:0] sh_col_q;
  logic [NUM_SPRITES-1:0]              sh_en_q;

  // Per-pixel hit and collision terms
  logic [NUM_SPRITES-1:0]  hit;
  logic [NUM_SPRITES-1:0]  multi_hit;
  logic                    bg_opaque;
  logic [COLOUR_WIDTH-1:0] pix_colour;

  // Collision accumulators and published flags
  logic [NUM_SPRITES-1:0] acc_sprite_q, acc_sprite_d;
  logic [NUM_SPRITES-1:0] acc_bg_q, acc_bg_d;
  logic [NUM_SPRITES-1:0] hit_sprite_q, hit_bg_q;

  // Registered pixel
  logic [X_WIDTH-1:0]      x_out_q;
  logic [Y_WIDTH-1:0]      y_out_q;
  logic [COLOUR_WIDTH-1:0] colour_out_q;
  logic                    valid_out_q, frame_start_q, frame_done_q;

  // ---------------------------------------------------------------------------
  // Scan counter next state. >= rather than == so a max shrinking below the
  // current position still wraps on the next enabled cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    last_x      = (scan_x_q >= max_x);
    last_y      = (scan_y_q >= max_y);
    last_pixel  = last_x && last_y;
    first_pixel = (scan_x_q == '0) && (scan_y_q == '0);
    scan_x_d    = scan_x_q + X_WIDTH'(1);
    scan_y_d    = scan_y_q;
    if (last_x) begin
      scan_x_d = '0;
      scan_y_d = last_y ? '0 : scan_y_q + Y_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sprite hit tests against the shadow set
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    logic [X_WIDTH-1:0]    sx;
    logic [Y_WIDTH-1:0]    sy;
    logic [SIZE_WIDTH-1:0] sw;
    logic [SIZE_WIDTH-1:0] sh;
    logic [XS-1:0]         px, x_lo, x_hi;
    logic [YS-1:0]         py, y_lo, y_hi;

    assign sx   = sh_x_q[g*X_WIDTH +: X_WIDTH];
    assign sy   = sh_y_q[g*Y_WIDTH +: Y_WIDTH];
    assign sw   = sh_w_q[g*SIZE_WIDTH +: SIZE_WIDTH];
    assign sh   = sh_h_q[g*SIZE_WIDTH +: SIZE_WIDTH];
    assign px   = XS'(scan_x_q);
    assign py   = YS'(scan_y_q);
    assign x_lo = XS'(sx);
    assign y_lo = YS'(sy);
    assign x_hi = XS'(sx) + XS'(sw);
    assign y_hi = YS'(sy) + YS'(sh);

    assign hit[g] = sh_en_q[g] && (sw != '0) && (sh != '0) &&
                    (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);

    // Sprite g overlaps at least one other sprite on this pixel
    assign multi_hit[g] = hit[g] && ((hit & ~(NUM_SPRITES'(1) << g)) != '0);
  end

  assign bg_opaque = (bg_flag != '0);

  // Lowest index wins: walk from the top so the lowest hit is written last.
  always_comb begin
    pix_colour = bg_opaque ? bg_flag : BG_COLOUR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pix_colour = sh_col_q[i*COLOUR_WIDTH +: COLOUR_WIDTH];
      end
    end
  end

  always_comb begin
    acc_sprite_d = acc_sprite_q | multi_hit;
    acc_bg_d     = acc_bg_q | (hit & {NUM_SPRITES{bg_opaque}});
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_x_q      <= '0;
      scan_y_q      <= '0;
      sh_x_q        <= '0;
      sh_y_q        <= '0;
      sh_w_q        <= '0;
      sh_h_q        <= '0;
      sh_col_q      <= '0;
      sh_en_q       <= '0;
      acc_sprite_q  <= '0;
      acc_bg_q      <= '0;
      hit_sprite_q  <= '0;
      hit_bg_q      <= '0;
      x_out_q       <= '0;
      y_out_q       <= '0;
      colour_out_q  <= '0;
      valid_out_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else if (enable) begin
      scan_x_q      <= scan_x_d;
      scan_y_q      <= scan_y_d;
      x_out_q       <= scan_x_q;
      y_out_q       <= scan_y_q;
      colour_out_q  <= pix_colour;
      valid_out_q   <= 1'b1;
      frame_start_q <= first_pixel;
      frame_done_q  <= last_pixel;
      if (last_pixel) begin
        // Publish this frame's collisions (including the last pixel) and
        // latch the sprite set for the next frame.
        hit_sprite_q <= acc_sprite_d;
        hit_bg_q     <= acc_bg_d;
        acc_sprite_q <= '0;
        acc_bg_q     <= '0;
        sh_x_q       <= sprite_x;
        sh_y_q       <= sprite_y;
        sh_w_q       <= sprite_w;
        sh_h_q       <= sprite_h;
        sh_col_q     <= sprite_colour;
        sh_en_q      <= sprite_en;
      end else begin
        acc_sprite_q <= acc_sprite_d;
        acc_bg_q     <= acc_bg_d;
      end
    end else begin
      // Pixel outputs hold; only the qualifiers drop so no pulse repeats.
      valid_out_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end
  end

  assign scan_x      = scan_x_q;
  assign scan_y      = scan_y_q;
  assign x_out       = x_out_q;
  assign y_out       = y_out_q;
  assign colour_out  = colour_out_q;
  assign valid_out   = valid_out_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign hit_sprite  = hit_sprite_q;
  assign hit_bg      = hit_bg_q;

endmodule
